uart_rx_sequencer: RTL and testbench

// - Receive control unit for the APB UART receiver. Sequences the SIPO shift register
//   (drives its shift enable) and the RX data buffer load.
// - Detects the start bit, times each bit period, validates the stop bit and reports

---
 rtl/uart_rx_sequencer_if.sv | 28 ++
 rtl/uart_rx_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Signal bundle between the UART RX sequencer and its neighbours: synchronized
// RX line and APB controls in, SIPO/RX-buffer strobes and sticky status out.
interface uart_rx_sequencer_if #(
    parameter int unsigned PERIOD_W = 14
);
    logic                serial_in;
    logic [PERIOD_W-1:0] bit_period;
    logic                data_read;
    logic                shift_strobe;
    logic                load_buffer;
    logic                rx_busy;
    logic                data_ready;
    logic                framing_error;
    logic                overrun_error;
    logic                parity_error;

    modport slave (
        input  serial_in, bit_period, data_read,
        output shift_strobe, load_buffer, rx_busy,
               data_ready, framing_error, overrun_error, parity_error
    );

    modport master (
        output serial_in, bit_period, data_read,
        input  shift_strobe, load_buffer, rx_busy,
               data_ready, framing_error, overrun_error, parity_error
    );
endinterface

// File: rtl/uart_rx_sequencer.sv
// Receive control unit of the APB UART: start detect, bit timing, SIPO strobes,
// RX buffer load and sticky status. Optional even-parity check via PARITY_CHECK_EN.
module uart_rx_sequencer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PERIOD_W  = 14
) (
    input  logic                clk,
    input  logic                n_rst,
    uart_rx_sequencer_if.slave  rx_bus
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_CHK,
        S_DATA,
`ifdef PARITY_CHECK_EN
        S_PARITY,
`endif
        S_STOP,
        S_LOAD
    } state_e;

    state_e              state_q, state_d;
    logic                prev_rx_q, prev_rx_d;
    logic [PERIOD_W-1:0] tmr_q, tmr_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                stop_ok_q, stop_ok_d;
    logic                shift_strobe_q, shift_strobe_d;
    logic                load_buffer_q, load_buffer_d;
    logic                rx_busy_q, rx_busy_d;
    logic                data_ready_q, data_ready_d;
    logic                framing_error_q, framing_error_d;
    logic                overrun_error_q, overrun_error_d;
`ifdef PARITY_CHECK_EN
    logic                par_acc_q, par_acc_d;
    logic                par_bad_q, par_bad_d;
    logic                parity_error_q, parity_error_d;
`endif

    logic                serial_in;
    logic                data_read;
    logic [PERIOD_W-1:0] period_clamped;
    logic [CNT_W-1:0]    bit_cnt_inc;
    logic                tmr_done;

    assign serial_in      = rx_bus.serial_in;
    assign data_read      = rx_bus.data_read;
    assign period_clamped = (rx_bus.bit_period < MIN_PERIOD) ? MIN_PERIOD : rx_bus.bit_period;
    assign bit_cnt_inc    = bit_cnt_q + CNT_W'(1);
    assign tmr_done       = (tmr_q == PERIOD_W'(1));

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= S_IDLE;
            prev_rx_q       <= 1'b1;
            tmr_q           <= '0;
            period_q        <= '0;
            bit_cnt_q       <= '0;
            stop_ok_q       <= 1'b0;
            shift_strobe_q  <= 1'b0;
            load_buffer_q   <= 1'b0;
            rx_busy_q       <= 1'b0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_acc_q       <= 1'b0;
            par_bad_q       <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            prev_rx_q       <= prev_rx_d;
            tmr_q           <= tmr_d;
            period_q        <= period_d;
            bit_cnt_q       <= bit_cnt_d;
            stop_ok_q       <= stop_ok_d;
            shift_strobe_q  <= shift_strobe_d;
            load_buffer_q   <= load_buffer_d;
            rx_busy_q       <= rx_busy_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
`ifdef PARITY_CHECK_EN
            par_acc_q       <= par_acc_d;
            par_bad_q       <= par_bad_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    // Next state; each timed state acts in the cycle its timer reads 1
    always_comb begin
        state_d         = state_q;
        prev_rx_d       = serial_in;
        tmr_d           = (tmr_q != '0) ? tmr_q - PERIOD_W'(1) : tmr_q;
        period_d        = period_q;
        bit_cnt_d       = bit_cnt_q;
        stop_ok_d       = stop_ok_q;
        shift_strobe_d  = 1'b0;
        load_buffer_d   = 1'b0;
        data_ready_d    = data_ready_q;
        framing_error_d = framing_error_q;
        overrun_error_d = overrun_error_q;
`ifdef PARITY_CHECK_EN
        par_acc_d       = par_acc_q;
        par_bad_d       = par_bad_q;
        parity_error_d  = parity_error_q;
`endif

        // Read clears status; sets further down win
        if (data_read) begin
            data_ready_d    = 1'b0;
            framing_error_d = 1'b0;
            overrun_error_d = 1'b0;
`ifdef PARITY_CHECK_EN
            parity_error_d  = 1'b0;
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (prev_rx_q && !serial_in) begin
                    state_d  = S_START_CHK;
                    period_d = period_clamped;
                    tmr_d    = period_clamped >> 1;
                end
            end
            S_START_CHK: begin
                if (tmr_done) begin
                    if (!serial_in) begin
                        state_d   = S_DATA;
                        tmr_d     = period_q;
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        par_acc_d = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tmr_done) begin
                    shift_strobe_d = 1'b1;
                    bit_cnt_d      = bit_cnt_inc;
                    tmr_d          = period_q;
`ifdef PARITY_CHECK_EN
                    par_acc_d      = par_acc_q ^ serial_in;
`endif
                    if (bit_cnt_inc >= CNT_W'(DATA_BITS)) begin
`ifdef PARITY_CHECK_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (tmr_done) begin
                    par_bad_d = par_acc_q ^ serial_in;
                    state_d   = S_STOP;
                    tmr_d     = period_q;
                end
            end
`endif
            S_STOP: begin
                if (tmr_done) begin
                    stop_ok_d     = serial_in;
                    load_buffer_d = serial_in;
                    state_d       = S_LOAD;
                    tmr_d         = '0;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                if (stop_ok_q) begin
                    data_ready_d = 1'b1;
                    if (data_ready_q && !data_read) begin
                        overrun_error_d = 1'b1;
                    end
                end else begin
                    framing_error_d = 1'b1;
                end
`ifdef PARITY_CHECK_EN
                if (par_bad_q) begin
                    parity_error_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    assign rx_bus.shift_strobe  = shift_strobe_q;
    assign rx_bus.load_buffer   = load_buffer_q;
    assign rx_bus.rx_busy       = rx_busy_q;
    assign rx_bus.data_ready    = data_ready_q;
    assign rx_bus.framing_error = framing_error_q;
    assign rx_bus.overrun_error = overrun_error_q;
`ifdef PARITY_CHECK_EN
    assign rx_bus.parity_error  = parity_error_q;
`else
    assign rx_bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: 8-bit frames at 16 clocks per bit,
// glitch rejection, framing/overrun status, mid-frame reset (and parity when enabled).
module tb_uart_rx_sequencer;

    localparam int unsigned PERIOD_W = 14;
    localparam int BIT_CLKS = 16;
`ifdef PARITY_CHECK_EN
    localparam int LOAD_GAP = 2 * BIT_CLKS;
`else
    localparam int LOAD_GAP = BIT_CLKS;
`endif

    logic clk;
    logic n_rst;

    uart_rx_sequencer_if #(.PERIOD_W(PERIOD_W)) rx_if ();

    uart_rx_sequencer #(
        .DATA_BITS (8),
        .PERIOD_W  (PERIOD_W)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .rx_bus (rx_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int strobe_cnt, load_cnt, spacing_bad;
    int first_strobe_cyc, last_strobe_cyc, last_load_cyc;
    int fall_cyc;
    logic dr_in_load, dr_after_load;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes and loads away from the active edge
    always @(negedge clk) begin
        if (rx_if.shift_strobe === 1'b1) begin
            if (strobe_cnt == 0)
                first_strobe_cyc = cyc;
            else if (cyc - last_strobe_cyc != BIT_CLKS)
                spacing_bad++;
            last_strobe_cyc = cyc;
            strobe_cnt++;
        end
        if (load_cnt > 0 && cyc == last_load_cyc + 1)
            dr_after_load = rx_if.data_ready;
        if (rx_if.load_buffer === 1'b1) begin
            load_cnt++;
            last_load_cyc = cyc;
            dr_in_load    = rx_if.data_ready;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        strobe_cnt       = 0;
        load_cnt         = 0;
        spacing_bad      = 0;
        first_strobe_cyc = 0;
        last_strobe_cyc  = 0;
        last_load_cyc    = 0;
        dr_in_load       = 1'bx;
        dr_after_load    = 1'bx;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_if.serial_in = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_head(input logic [7:0] d);
        fall_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_head(d);
`ifdef PARITY_CHECK_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic pulse_read();
        rx_if.data_read = 1'b1;
        wait_clks(1);
        rx_if.data_read = 1'b0;
    endtask

    initial begin
        logic seen;
        n_rst            = 1'b0;
        rx_if.serial_in  = 1'b1;
        rx_if.bit_period = PERIOD_W'(BIT_CLKS);
        rx_if.data_read  = 1'b0;
        clear_mon();

        // Reset state
        #2;
        chk("rst_busy",    32'(rx_if.rx_busy),       32'd0);
        chk("rst_strobe",  32'(rx_if.shift_strobe),  32'd0);
        chk("rst_load",    32'(rx_if.load_buffer),   32'd0);
        chk("rst_status",  32'({rx_if.data_ready, rx_if.framing_error,
                                rx_if.overrun_error, rx_if.parity_error}), 32'd0);
        #20 n_rst = 1'b1;
        wait_clks(3);

        // Frame 0xA5: timing of strobes and load
        clear_mon();
        send_frame(8'hA5, 1'b1);
        chk("a5_strobes",     32'(strobe_cnt), 32'd8);
        chk("a5_first",       32'(first_strobe_cyc - fall_cyc), 32'd24);
        chk("a5_spacing",     32'(spacing_bad), 32'd0);
        chk("a5_loads",       32'(load_cnt), 32'd1);
        chk("a5_load_gap",    32'(last_load_cyc - last_strobe_cyc), 32'(LOAD_GAP));
        chk("a5_dr_in_load",  32'(dr_in_load), 32'd0);
        chk("a5_dr_after",    32'(dr_after_load), 32'd1);
        chk("a5_errs",        32'({rx_if.framing_error, rx_if.overrun_error,
                                   rx_if.parity_error}), 32'd0);
        chk("a5_idle",        32'(rx_if.rx_busy), 32'd0);

        // Glitch of 5 clocks: rejected, status untouched
        clear_mon();
        rx_if.serial_in = 1'b0;
        wait_clks(3);
        chk("gl_busy_mid", 32'(rx_if.rx_busy), 32'd1);
        wait_clks(2);
        rx_if.serial_in = 1'b1;
        wait_clks(30);
        chk("gl_strobes", 32'(strobe_cnt), 32'd0);
        chk("gl_loads",   32'(load_cnt), 32'd0);
        chk("gl_busy",    32'(rx_if.rx_busy), 32'd0);
        chk("gl_dr",      32'(rx_if.data_ready), 32'd1);

        pulse_read();
        chk("rd_dr_clr", 32'(rx_if.data_ready), 32'd0);

        // Stop bit low: framing error, no load, line held low gives no restart
        clear_mon();
        send_frame(8'h3C, 1'b0);
        chk("fe_strobes", 32'(strobe_cnt), 32'd8);
        chk("fe_loads",   32'(load_cnt), 32'd0);
        chk("fe_flag",    32'(rx_if.framing_error), 32'd1);
        chk("fe_busy",    32'(rx_if.rx_busy), 32'd0);
        chk("fe_dr",      32'(rx_if.data_ready), 32'd0);
        wait_clks(40);
        chk("fe_low_busy",    32'(rx_if.rx_busy), 32'd0);
        chk("fe_low_strobes", 32'(strobe_cnt), 32'd8);
        rx_if.serial_in = 1'b1;
        wait_clks(3);
        pulse_read();
        chk("fe_clr", 32'(rx_if.framing_error), 32'd0);

        // Back-to-back frames with no read: overrun
        clear_mon();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("ov_strobes", 32'(strobe_cnt), 32'd16);
        chk("ov_loads",   32'(load_cnt), 32'd2);
        chk("ov_flag",    32'(rx_if.overrun_error), 32'd1);
        chk("ov_dr",      32'(rx_if.data_ready), 32'd1);
        pulse_read();
        chk("ov_clr", 32'({rx_if.data_ready, rx_if.overrun_error}), 32'd0);

        // Read coinciding with LOAD: no overrun
        clear_mon();
        send_frame(8'h33, 1'b1);
        send_head(8'h44);
`ifdef PARITY_CHECK_EN
        send_bit(^(8'h44));
`endif
        rx_if.serial_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_clks(1);
            if (rx_if.load_buffer === 1'b1) begin
                seen = 1'b1;
                pulse_read();
                break;
            end
        end
        chk("rl_load_seen", 32'(seen), 32'd1);
        wait_clks(10);
        chk("rl_overrun", 32'(rx_if.overrun_error), 32'd0);
        chk("rl_dr",      32'(rx_if.data_ready), 32'd1);

        // Reset after 3 strobes aborts the frame
        clear_mon();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("mr_strobes", 32'(strobe_cnt), 32'd3);
        chk("mr_busy",    32'(rx_if.rx_busy), 32'd1);
        rx_if.serial_in = 1'b0;
        wait_clks(4);
        #2 n_rst = 1'b0;
        #1;
        chk("mr_outs", 32'({rx_if.shift_strobe, rx_if.load_buffer, rx_if.rx_busy,
                            rx_if.data_ready, rx_if.framing_error,
                            rx_if.overrun_error, rx_if.parity_error}), 32'd0);
        rx_if.serial_in = 1'b1;
        #3 n_rst = 1'b1;
        wait_clks(5);
        clear_mon();
        send_frame(8'h5A, 1'b1);
        chk("mr_re_strobes", 32'(strobe_cnt), 32'd8);
        chk("mr_re_loads",   32'(load_cnt), 32'd1);
        chk("mr_re_dr",      32'(rx_if.data_ready), 32'd1);
        pulse_read();

`ifdef PARITY_CHECK_EN
        // 0x07 has three ones: even parity bit must be 1
        clear_mon();
        send_head(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("par_bad_flag", 32'(rx_if.parity_error), 32'd1);
        chk("par_bad_load", 32'(load_cnt), 32'd1);
        pulse_read();
        clear_mon();
        send_head(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("par_ok_flag", 32'(rx_if.parity_error), 32'd0);
        chk("par_ok_load", 32'(load_cnt), 32'd1);
`else
        chk("par_tied", 32'(rx_if.parity_error), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
